// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: sequences sb/sh/sw stores to a 64-bit data memory as
// read-modify-write transactions. Full-doubleword stores write directly.
// Optional byte-lane alignment is enabled by defining STORE_LANE_ALIGN_EN.
module store_rmw_ctrl #(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       inst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       reg_data,
    input  logic [63:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [63:0]       mem_wdata,
    output logic              stall,
    output logic              done
);
    localparam int unsigned CNT_W    = 4;
    localparam logic [6:0]  OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t            state;
    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       data_q;

    logic              detect;
    logic              rmw_in;
    logic              drop_in;
    logic [2:0]        f3_in;
    logic [5:0]        sh_in;
    logic [5:0]        sh_q;
    logic [ADDR_W-1:0] ea_in;
    logic [ADDR_W-1:0] ea_q;
    logic [63:0]       mask_q;
    logic [63:0]       merged;
    logic [63:0]       sd_data;
    logic              unused_inst;

    // Byte lanes replaced by the register value for each store width.
    function automatic logic [63:0] lane_mask(input logic [2:0] f3);
        case (f3)
            3'b000:  lane_mask = 64'h00000000_000000FF;
            3'b001:  lane_mask = 64'h00000000_0000FFFF;
            3'b010:  lane_mask = 64'h00000000_FFFFFFFF;
            default: lane_mask = 64'hFFFFFFFF_FFFFFFFF;
        endcase
    endfunction

    // Store decode on the MEM-stage instruction.
    assign f3_in       = inst[14:12];
    assign detect      = start && (inst[6:0] == OP_STORE);
    assign rmw_in      = (f3_in == 3'b000) || (f3_in == 3'b001) || (f3_in == 3'b010);
    assign unused_inst = ^{inst[31:15], inst[11:7]};

`ifdef STORE_LANE_ALIGN_EN
    // Doubleword-aligned address, lane shift from the byte offset, and
    // detection of stores that would spill into the next doubleword.
    assign sh_in   = {addr[2:0], 3'b000};
    assign sh_q    = {addr_q[2:0], 3'b000};
    assign ea_in   = {addr[ADDR_W-1:3], 3'b000};
    assign ea_q    = {addr_q[ADDR_W-1:3], 3'b000};
    assign drop_in = ((f3_in == 3'b001) && (addr[2:0] == 3'd7)) ||
                     ((f3_in == 3'b010) && (addr[2:0] > 3'd4));
`else
    assign sh_in   = 6'd0;
    assign sh_q    = 6'd0;
    assign ea_in   = addr;
    assign ea_q    = addr_q;
    assign drop_in = 1'b0;
`endif

    // Merge: register lanes under the mask, memory lanes elsewhere.
    assign mask_q  = lane_mask(f3_q) << sh_q;
    assign merged  = ((data_q << sh_q) & mask_q) | (mem_rdata & ~mask_q);
    assign sd_data = reg_data << sh_in;

    // Stall is combinational in IDLE so the store freezes the pipe at once.
    assign stall = !reset && (busy || ((state == IDLE) && detect));

    // Sequencer with registered memory strobes, address, data and done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            f3_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            done      <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            mem_addr  <= '0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (detect) begin
                        f3_q   <= f3_in;
                        addr_q <= addr;
                        data_q <= reg_data;
                        if (drop_in) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (rmw_in) begin
                            state     <= READ;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= ea_in;
                        end else begin
                            state     <= WRITE;
                            busy      <= 1'b1;
                            mem_wr_en <= 1'b1;
                            mem_addr  <= ea_in;
                            mem_wdata <= sd_data;
                        end
                    end
                end
                READ: begin
                    state    <= WAIT;
                    cnt      <= CNT_W'(READ_LAT);
                    mem_addr <= ea_q;
                end
                WAIT: begin
                    mem_addr <= ea_q;
                    if (cnt == CNT_W'(1)) begin
                        state     <= WRITE;
                        mem_wr_en <= 1'b1;
                        mem_wdata <= merged;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WRITE: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// tb_store_rmw_ctrl: randomized self-checking bench for store_rmw_ctrl with a
// transaction-level byte-merge reference model and a fixed-latency memory.
module tb_store_rmw_ctrl;
    localparam int unsigned LAT = 3;
    localparam int unsigned AW  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   inst;
    logic [AW-1:0] addr;
    logic [63:0]   reg_data;
    logic [63:0]   mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [63:0]   mem_wdata;
    logic          stall;
    logic          done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    store_rmw_ctrl #(.READ_LAT(LAT), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .inst     (inst),
        .addr     (addr),
        .reg_data (reg_data),
        .mem_rdata(mem_rdata),
        .mem_addr (mem_addr),
        .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata),
        .stall    (stall),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] op);
        return {17'($urandom), f3, 5'($urandom), op};
    endfunction

    // Reference model: store width in bytes, byte offset, target address, merge.
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int offset(input logic [63:0] a);
`ifdef STORE_LANE_ALIGN_EN
        return int'(a[2:0]);
`else
        return 0;
`endif
    endfunction

    function automatic logic [63:0] exp_addr(input logic [63:0] a);
        return a - 64'(offset(a));
    endfunction

    function automatic logic [63:0] exp_wdata(input logic [2:0] f3, input logic [63:0] a,
                                              input logic [63:0] d, input logic [63:0] m);
        logic [63:0] r;
        int off;
        r   = m;
        off = offset(a);
        for (int i = 0; i < nbytes(f3); i++) r[(off + i) * 8 +: 8] = d[i * 8 +: 8];
        return r;
    endfunction

    task automatic drive(input logic s, input logic [31:0] in, input logic [63:0] a,
                         input logic [63:0] d, input logic [63:0] rd);
        @(posedge clk);
        #1;
        start     = s;
        inst      = in;
        addr      = a;
        reg_data  = d;
        mem_rdata = rd;
    endtask

    // Busy-cycle inputs: start held, other inputs scrambled; must be ignored.
    task automatic drive_busy(input logic [31:0] in, input logic [63:0] rd);
        logic [31:0] i2;
        i2 = ($urandom_range(0, 1) == 0) ? in : $urandom;
        drive(1'b1, i2, rand64(), rand64(), rd);
    endtask

    task automatic expect_cycle(input string tag, input logic rd, input logic wr,
                                input logic st, input logic dn,
                                input logic ca, input logic [63:0] ea,
                                input logic cw, input logic [63:0] ew);
        @(negedge clk);
        check({tag, ".ctl"}, 64'({mem_rd_en, mem_wr_en, stall, done}), 64'({rd, wr, st, dn}));
        if (ca) check({tag, ".addr"}, mem_addr, ea);
        if (cw) check({tag, ".wdata"}, mem_wdata, ew);
    endtask

    task automatic idle_cycle();
        drive(1'b0, $urandom, rand64(), rand64(), rand64());
        expect_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1, 64'd0);
    endtask

    // One instruction presented in IDLE, followed through to completion.
    task automatic run_store(input logic [31:0] in, input logic [63:0] a,
                             input logic [63:0] d, input logic [63:0] m);
        logic [2:0]  f3;
        logic        is_st;
        logic [63:0] ea;
        logic [63:0] ed;
        f3    = in[14:12];
        is_st = (in[6:0] == 7'b0100011);
        ea    = exp_addr(a);
        ed    = exp_wdata(f3, a, d, m);
        drive(1'b1, in, a, d, rand64());
        expect_cycle("accept", 1'b0, 1'b0, is_st, 1'b0, 1'b1, 64'd0, 1'b1, 64'd0);
        if (!is_st) return;
        if (offset(a) + nbytes(f3) > 8) begin
            drive_busy(in, rand64());
            expect_cycle("drop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1, 64'd0);
            return;
        end
        if (nbytes(f3) == 8) begin
            drive_busy(in, rand64());
            expect_cycle("sd_wr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ea, 1'b1, ed);
            drive_busy(in, rand64());
            expect_cycle("sd_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1, 64'd0);
            return;
        end
        drive_busy(in, rand64());
        expect_cycle("rd", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ea, 1'b0, 64'd0);
        for (int k = 2; k <= LAT + 1; k++) begin
            drive_busy(in, (k == LAT + 1) ? m : rand64());
            expect_cycle("wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        end
        drive_busy(in, rand64());
        expect_cycle("wr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ea, 1'b1, ed);
        drive_busy(in, rand64());
        expect_cycle("done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1, 64'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [6:0]  op;
        logic [63:0] a;
        logic [31:0] sb_inst;

        reset     = 1'b1;
        start     = 1'b0;
        inst      = '0;
        addr      = '0;
        reg_data  = '0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.ctl", 64'({mem_rd_en, mem_wr_en, stall, done}), 64'd0);
        check("reset.addr", mem_addr, 64'd0);
        check("reset.wdata", mem_wdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed: sb, sw, sd, load, back-to-back sh.
        run_store(mk_inst(3'b000, 7'b0100011), 64'h1000, 64'h11223344_556677AB, 64'hFFEEDDCC_BBAA9988);
        run_store(mk_inst(3'b010, 7'b0100011), 64'h2000, 64'h11223344_556677AB, 64'hFFEEDDCC_BBAA9988);
        run_store(mk_inst(3'b111, 7'b0100011), 64'h3000, 64'hDEADBEEF_01234567, rand64());
        run_store(mk_inst(3'b011, 7'b0000011), 64'h4000, rand64(), rand64());
        idle_cycle();
        run_store(mk_inst(3'b001, 7'b0100011), 64'h5002, 64'h0000_0000_0000_CAFE, rand64());
        run_store(mk_inst(3'b001, 7'b0100011), 64'h6004, 64'h0000_0000_0000_BABE, rand64());
        idle_cycle();

`ifdef STORE_LANE_ALIGN_EN
        run_store(mk_inst(3'b001, 7'b0100011), 64'h1006, 64'h0000_0000_0000_BEEF, 64'd0);
        run_store(mk_inst(3'b001, 7'b0100011), 64'h1007, 64'h0000_0000_0000_BEEF, 64'd0);
        run_store(mk_inst(3'b010, 7'b0100011), 64'h1005, rand64(), rand64());
        idle_cycle();
`endif

        // Reset while an sb is waiting for read data.
        sb_inst = mk_inst(3'b000, 7'b0100011);
        drive(1'b1, sb_inst, 64'h7000, rand64(), rand64());
        expect_cycle("r_accept", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'd0, 1'b1, 64'd0);
        drive_busy(sb_inst, rand64());
        expect_cycle("r_rd", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h7000, 1'b0, 64'd0);
        drive_busy(sb_inst, rand64());
        expect_cycle("r_wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        drive_busy(sb_inst, rand64());
        #1;
        reset = 1'b1;
        #1;
        check("midrst.ctl", 64'({mem_rd_en, mem_wr_en, stall, done}), 64'd0);
        check("midrst.addr", mem_addr, 64'd0);
        check("midrst.wdata", mem_wdata, 64'd0);
        for (int k = 0; k < LAT + 3; k++) begin
            @(posedge clk);
            #1;
            check("inrst.ctl", 64'({mem_rd_en, mem_wr_en, stall, done}), 64'd0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        idle_cycle();
        idle_cycle();
        run_store(mk_inst(3'b111, 7'b0100011), 64'h8000, rand64(), rand64());

        // Randomized mix of stores, non-store opcodes and idle cycles.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0: idle_cycle();
                1: begin
                    op = 7'($urandom);
                    if (op == 7'b0100011) op = 7'b0000011;
                    run_store(mk_inst(3'($urandom), op), rand64(), rand64(), rand64());
                end
                default: begin
                    f3 = 3'($urandom);
                    a  = rand64();
`ifdef STORE_LANE_ALIGN_EN
                    if (nbytes(f3) == 8) a[2:0] = 3'b000;
`endif
                    run_store(mk_inst(f3, 7'b0100011), a, rand64(), rand64());
                end
            endcase
        end
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
